// File: rtl/dclkfifolut_reader.sv
// rtl/dclkfifolut_reader.sv - read-side adapter from a dual-clock LUT FIFO to a framed valid/ready stream
//
// Drains the FIFO read port and hides its one-cycle read latency behind a
// 2-entry prefetch buffer, sustaining one word per cycle when the consumer
// is always ready. Words are framed into packets of PKT_LEN beats.
//
// Ports:
//   rclk     - read-domain clock
//   rsrst    - synchronous active-high reset (shared with FIFO read side)
//   flush    - drop buffered and in-flight words, restart packet framing
//   ren      - FIFO read enable (combinational, depends on m_ready)
//   rdata    - FIFO read data, valid the cycle after an accepted read
//   rempty   - FIFO empty flag (registered in the FIFO)
//   m_valid  - stream word available
//   m_ready  - consumer accepts the word
//   m_data   - stream word (buffer head register)
//   m_last   - last word of a packet, qualified by m_valid

module dclkfifolut_reader #(
   parameter int FIFO_WIDTH = 8,
   parameter int PKT_LEN    = 4
) (
   input  logic                  rclk,
   input  logic                  rsrst,
   input  logic                  flush,
   output logic                  ren,
   input  logic [FIFO_WIDTH-1:0] rdata,
   input  logic                  rempty,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_last
);

   localparam int               CNT_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PKT_LEN - 1);

   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q, inflight_d;
   logic [FIFO_WIDTH-1:0] head_q, head_d;
   logic [FIFO_WIDTH-1:0] tail_q, tail_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  pop;
   logic [2:0]            held_after_pop;

   always_comb begin
      m_valid = (occ_q != 2'd0);
      m_data  = head_q;
      m_last  = m_valid & (cnt_q == CNT_MAX);
      pop     = m_valid & m_ready;

      // Words the buffer must still make room for once this cycle's pop
      // retires; a new read is only safe while that leaves a free slot.
      held_after_pop = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
      ren = ~rsrst & ~flush & ~rempty & (held_after_pop <= 3'd1);

      // ren already excludes rempty, so it equals the accepted-read strobe.
      inflight_d = ren;

      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;

      if (flush) begin
         // The landing word (if any) is dropped along with the buffer.
         occ_d = 2'd0;
         cnt_d = '0;
      end else begin
         if (pop) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
         end
         if (inflight_q) begin
            // occ == 2 with a landing word is excluded by the ren limit.
            if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
               head_d = rdata;
               occ_d  = 2'd1;
            end else begin
               tail_d = rdata;
               occ_d  = 2'd2;
            end
         end else if (pop) begin
            if (occ_q == 2'd2) begin
               head_d = tail_q;
               occ_d  = 2'd1;
            end else begin
               occ_d  = 2'd0;
            end
         end
      end
   end

   always_ff @(posedge rclk) begin
      if (rsrst) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         cnt_q      <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_dclkfifolut_reader.sv
// tb/tb_dclkfifolut_reader.sv - self-checking bench for dclkfifolut_reader

module tb_dclkfifolut_reader;

   localparam int PKT_LEN = 4;

   typedef struct {
      logic [7:0] w;
      int         t;
   } ent_t;

   typedef struct {
      logic [7:0] d;
      logic       l;
      int         t;
   } dl_t;

   logic       rclk = 1'b0;
   logic       rsrst = 1'b1;
   logic       flush = 1'b0;
   logic       m_ready = 1'b0;
   logic       ren, m_valid, m_last;
   logic [7:0] m_data;
   logic       u1_ren, u1_m_valid, u1_m_last;
   logic [7:0] u1_m_data;
   logic [7:0] rdata = 8'h00;
   logic       rempty = 1'b1;
   logic [7:0] rdata_nx = 8'h00;
   logic       rempty_nx = 1'b1;

   logic       wr_push = 1'b0;
   logic [7:0] wr_val = 8'h00;

   logic [7:0] fq[$];
   ent_t       pend[$];
   dl_t        dlog[$];
   int         cyc = 0;
   int         beats = 0;
   int         discarded = 0;
   int         n_chk = 0;
   int         n_err = 0;
   bit         chk_on = 1'b0;

   always #5 rclk = ~rclk;

   dclkfifolut_reader #(.FIFO_WIDTH(8), .PKT_LEN(PKT_LEN)) u_dut (
      .rclk(rclk), .rsrst(rsrst), .flush(flush), .ren(ren), .rdata(rdata),
      .rempty(rempty), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_last(m_last)
   );

   dclkfifolut_reader #(.FIFO_WIDTH(8), .PKT_LEN(1)) u_dut1 (
      .rclk(rclk), .rsrst(rsrst), .flush(flush), .ren(u1_ren), .rdata(rdata),
      .rempty(rempty), .m_valid(u1_m_valid), .m_ready(m_ready), .m_data(u1_m_data),
      .m_last(u1_m_last)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: every word read out of the FIFO joins pend with its read
   // cycle; it becomes visible two cycles later and leaves in order on pop.
   always @(negedge rclk) begin
      bit         ev, ep, er, el;
      logic [7:0] ed;
      logic [7:0] w;
      ev = 1'b0;
      if (pend.size() > 0) ev = (pend[0].t + 2 <= cyc);
      ed = ev ? pend[0].w : 8'h00;
      el = ev && (beats == PKT_LEN - 1);
      ep = ev && m_ready;
      er = !rsrst && !flush && !rempty && (pend.size() - (ep ? 1 : 0) <= 1);
      if (chk_on) begin
         chk("ren", ren, er);
         chk("m_valid", m_valid, ev);
         chk("m_last", m_last, el);
         if (ev) chk("m_data", m_data, ed);
         chk("held_le_2", pend.size() <= 2, 1);
         chk("u1_ren", u1_ren, er);
         chk("u1_m_valid", u1_m_valid, ev);
         chk("u1_m_last", u1_m_last, ev);
         if (ev) chk("u1_m_data", u1_m_data, ed);
      end
      if (rsrst) begin
         fq.delete();
         pend.delete();
         beats = 0;
         rempty_nx = 1'b1;
      end else begin
         if (ep) begin
            void'(pend.pop_front());
            beats = (beats + 1) % PKT_LEN;
            dlog.push_back('{m_data, m_last, cyc});
         end
         if (ren === 1'b1 && !rempty && fq.size() > 0) begin
            w = fq.pop_front();
            pend.push_back('{w, cyc});
            rdata_nx = w;
         end
         if (flush) begin
            discarded += pend.size();
            pend.delete();
            beats = 0;
         end
         if (wr_push) fq.push_back(wr_val);
         rempty_nx = (fq.size() == 0);
      end
      cyc++;
   end

   always @(posedge rclk) begin
      rdata  <= rdata_nx;
      rempty <= rempty_nx;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge rclk);
      #1;
   endtask

   task automatic write_seq(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         wr_push = 1'b1;
         wr_val  = first + 8'(i);
         step();
      end
      wr_push = 1'b0;
   endtask

   task automatic wait_log(input int n, input int budget);
      for (int i = 0; i < budget && dlog.size() < n; i++) step();
      chk("wait_log_count", dlog.size(), n);
   endtask

   initial begin
      logic [7:0] lastp;
      int         sent;
      int         k;

      // Reset state
      step();
      chk_on = 1'b1;
      step();
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_ren", ren, 0);
      rsrst = 1'b0;
      step();

      // Full throughput, PKT_LEN = 4 framing
      dlog.delete();
      m_ready = 1'b1;
      write_seq(8'h01, 16);
      wait_log(16, 40);
      if (dlog.size() == 16) begin
         for (int i = 0; i < 16; i++) begin
            chk("tp_data", dlog[i].d, i + 1);
            chk("tp_last", dlog[i].l, ((i + 1) % 4) == 0);
         end
         chk("tp_no_gap", dlog[15].t - dlog[0].t, 15);
      end

      // Back-pressure: only two words leave the FIFO while stalled
      dlog.delete();
      m_ready = 1'b0;
      write_seq(8'h21, 8);
      chk("bp_head_early", m_data, 8'h21);
      repeat (10) step();
      chk("bp_fifo_level", fq.size(), 6);
      chk("bp_valid", m_valid, 1);
      chk("bp_head_stable", m_data, 8'h21);
      m_ready = 1'b1;
      wait_log(8, 30);
      if (dlog.size() == 8) begin
         for (int i = 0; i < 8; i++) chk("bp_data", dlog[i].d, 8'h21 + i);
         chk("bp_no_gap", dlog[7].t - dlog[0].t, 7);
         chk("bp_last4", dlog[3].l, 1);
         chk("bp_last8", dlog[7].l, 1);
      end

      // Flush with one word buffered and one in flight
      dlog.delete();
      m_ready = 1'b0;
      write_seq(8'h31, 6);
      repeat (4) step();
      chk("fl_pre_data", m_data, 8'h31);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_valid_after", m_valid, 0);
      chk("fl_popped_one", dlog.size(), 1);
      lastp = (dlog.size() > 0) ? dlog[0].d : 8'h00;
      dlog.delete();
      write_seq(8'h37, 1);
      m_ready = 1'b1;
      wait_log(4, 30);
      if (dlog.size() == 4) begin
         chk("fl_next_word", dlog[0].d, lastp + 8'd3);
         for (int i = 0; i < 4; i++) begin
            chk("fl_data", dlog[i].d, 8'h34 + i);
            chk("fl_last", dlog[i].l, i == 3);
         end
      end

      // Reset mid-stream with one word buffered and one in flight
      dlog.delete();
      m_ready = 1'b0;
      write_seq(8'h41, 3);
      k = 0;
      while (k < 20 && !(pend.size() == 2 && pend[0].t + 2 <= cyc && pend[1].t + 1 == cyc)) begin
         step();
         k++;
      end
      chk("mr_setup", k < 20, 1);
      rsrst = 1'b1;
      step();
      chk("mr_m_valid", m_valid, 0);
      chk("mr_m_data", m_data, 0);
      chk("mr_m_last", m_last, 0);
      chk("mr_ren", ren, 0);
      rsrst = 1'b0;
      step();
      m_ready = 1'b1;
      write_seq(8'h51, 4);
      wait_log(4, 30);
      if (dlog.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("mr_data", dlog[i].d, 8'h51 + i);
         chk("mr_last", dlog[3].l, 1);
      end

      // Latency of a single word into an idle reader, PKT_LEN = 1 framing
      repeat (3) step();
      wr_push = 1'b1;
      wr_val  = 8'h61;
      step();
      wr_push = 1'b0;
      chk("lat_ren", ren, 1);
      chk("lat_valid_t", m_valid, 0);
      step();
      chk("lat_valid_t1", m_valid, 0);
      step();
      chk("lat_valid_t2", m_valid, 1);
      chk("lat_data", m_data, 8'h61);
      chk("lat_u1_last", u1_m_last, 1);
      step();

      // Random ready and write bursts with rare flushes
      dlog.delete();
      discarded = 0;
      sent = 0;
      for (int c = 0; c < 6000 && sent < 1000; c++) begin
         m_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0) begin
            wr_push = 1'b1;
            wr_val  = 8'($urandom);
            sent++;
         end else begin
            wr_push = 1'b0;
         end
         flush = ($urandom_range(0, 199) == 0);
         step();
      end
      wr_push = 1'b0;
      flush   = 1'b0;
      m_ready = 1'b1;
      k = 0;
      while (k < 3000 && (fq.size() > 0 || pend.size() > 0)) begin
         step();
         k++;
      end
      chk("rand_drained", k < 3000, 1);
      chk("rand_total", dlog.size() + discarded, 1000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
